// File: rtl/pygmy_pkg.sv
// pygmy_pkg: shared constants and register-file state type
package pygmy_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: register-file port bundle (master: we/rd_ptr/rd/rs_ptr out, rs/ready in; slave mirrors)
interface regfile_mp_if #(
  parameter int XLEN = pygmy_pkg::XLEN,
  parameter int NREGS = 32,
  parameter int NRD = 2
);
  localparam int AW = $clog2(NREGS);
  logic we;
  logic [AW-1:0] rd_ptr;
  logic [XLEN-1:0] rd;
  logic [NRD*AW-1:0] rs_ptr;
  logic [NRD*XLEN-1:0] rs;
  logic ready;
  modport master (output we, rd_ptr, rd, rs_ptr, input rs, ready);
  modport slave (input we, rd_ptr, rd, rs_ptr, output rs, ready);
endinterface

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: post-reset clear sweep (clk_i, rst_i in; clr_we, clr_addr, ready out)
module regfile_clear_fsm
  import pygmy_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW = $clog2(NREGS)
) (
  input logic clk_i,
  input logic rst_i,
  output logic clr_we,
  output logic [AW-1:0] clr_addr,
  output logic ready
);
  rf_state_t state, state_nx;
  logic [AW-1:0] clr_cnt, cnt_nx;
  logic last;
  assign last = clr_cnt == AW'(NREGS - 1);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RF_CLEAR;
      clr_cnt <= AW'(1);
    end else begin
      state <= state_nx;
      clr_cnt <= cnt_nx;
    end
  end
  // counter saturates at NREGS-1 so it never wraps onto register 0
  always_comb begin
    clr_we = state == RF_CLEAR && !rst_i;
    cnt_nx = clr_we && !last ? clr_cnt + 1'b1 : clr_cnt;
    state_nx = clr_we && last ? RF_READY : state;
  end
  assign clr_addr = clr_cnt;
  assign ready = state == RF_READY;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read/1-write register file with x0=0, optional bypass, clear sweep (clk_i, rst_i, bus slave)
module regfile_mp #(
  parameter int XLEN = pygmy_pkg::XLEN,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter bit BYPASS = 1
) (
  input logic clk_i,
  input logic rst_i,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW:0] NR = (AW + 1)'(NREGS);
  logic [XLEN-1:0] mem [1:NREGS-1];
  logic clr_we, user_we, wen;
  logic [AW-1:0] clr_addr, waddr;
  logic [XLEN-1:0] wdata;
  regfile_clear_fsm #(.NREGS(NREGS), .AW(AW)) u_fsm (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_we(clr_we),
    .clr_addr(clr_addr),
    .ready(bus.ready)
  );
  assign user_we = bus.ready && bus.we && bus.rd_ptr != '0 && {1'b0, bus.rd_ptr} < NR && !rst_i;
  assign wen = clr_we || user_we;
  assign waddr = clr_we ? clr_addr : bus.rd_ptr;
  assign wdata = clr_we ? '0 : bus.rd;
  always_ff @(posedge clk_i) begin
    if (wen) mem[waddr] <= wdata;
  end
  for (genvar n = 0; n < NRD; n++) begin : g_rd
    logic [AW-1:0] ptr;
    assign ptr = bus.rs_ptr[n*AW +: AW];
    assign bus.rs[n*XLEN +: XLEN] =
      !bus.ready || ptr == '0 || {1'b0, ptr} >= NR ? '0 :
      BYPASS && bus.we && ptr == bus.rd_ptr ? bus.rd : mem[ptr];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized + directed check of regfile_mp against a behavioural model
module tb_regfile_mp;
  logic clk = 0, rst = 1, rst_c = 1;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) ia();
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) ib();
  regfile_mp_if #(.XLEN(16), .NREGS(24), .NRD(3)) ic();
  assign ib.we = ia.we;
  assign ib.rd_ptr = ia.rd_ptr;
  assign ib.rd = ia.rd;
  assign ib.rs_ptr = ia.rs_ptr;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut_a (.clk_i(clk), .rst_i(rst), .bus(ia));
  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ib));
  regfile_mp #(.XLEN(16), .NREGS(24), .NRD(3), .BYPASS(1)) dut_c (.clk_i(clk), .rst_i(rst_c), .bus(ic));

  int checks = 0, errors = 0;
  bit c_done = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: reset blanks everything; the file is unusable for NREGS-1 edges after release,
  // and since CLEAR ignores writes, contents are all-zero when it becomes usable.
  logic [31:0] ma [32];
  logic [15:0] mc [24];
  bit ra = 0, on_a = 0, rc = 0, on_c = 0;
  int sa = 0, sc = 0;

  always @(posedge clk) begin
    if (rst) begin
      on_a = 1; ra = 0; sa = 0;
      foreach (ma[i]) ma[i] = 0;
    end else if (on_a) begin
      if (ra && ia.we && ia.rd_ptr != 0) ma[ia.rd_ptr] = ia.rd;
      if (!ra) begin sa++; ra = sa >= 31; end
    end
  end

  always @(posedge clk) begin
    if (rst_c) begin
      on_c = 1; rc = 0; sc = 0;
      foreach (mc[i]) mc[i] = 0;
    end else if (on_c) begin
      if (rc && ic.we && ic.rd_ptr != 0 && ic.rd_ptr < 24) mc[ic.rd_ptr] = ic.rd;
      if (!rc) begin sc++; rc = sc >= 23; end
    end
  end

  logic [4:0] pa, pc;
  logic [31:0] sta, ea;
  logic [15:0] ec;
  always @(negedge clk) begin
    if (on_a) begin
      chk("ready_a", ia.ready, ra);
      chk("ready_b", ib.ready, ra);
      for (int p = 0; p < 2; p++) begin
        pa = ia.rs_ptr[p*5 +: 5];
        sta = (!ra || pa == 0) ? 32'h0 : ma[pa];
        ea = (ra && pa != 0 && ia.we && pa == ia.rd_ptr) ? ia.rd : sta;
        chk($sformatf("rs_a%0d", p), ia.rs[p*32 +: 32], ea);
        chk($sformatf("rs_b%0d", p), ib.rs[p*32 +: 32], sta);
      end
    end
    if (on_c) begin
      chk("ready_c", ic.ready, rc);
      for (int p = 0; p < 3; p++) begin
        pc = ic.rs_ptr[p*5 +: 5];
        if (!rc || pc == 0 || pc >= 24) ec = 0;
        else if (ic.we && pc == ic.rd_ptr) ec = ic.rd;
        else ec = mc[pc];
        chk($sformatf("rs_c%0d", p), ic.rs[p*16 +: 16], ec);
      end
    end
  end

  task automatic sweep_a(input bit clr_write, output int n);
    n = 0;
    while (!ia.ready && n < 100) begin
      ia.we = clr_write && n == 1;
      ia.rd_ptr = 3;
      ia.rd = 32'hCAFEF00D;
      ia.rs_ptr = $urandom;
      step();
      n++;
    end
    ia.we = 0;
  endtask

  task automatic sweep_c(output int n);
    n = 0;
    while (!ic.ready && n < 100) begin
      ic.we = $urandom_range(1);
      ic.rd_ptr = $urandom;
      ic.rd = $urandom;
      ic.rs_ptr = $urandom;
      step();
      n++;
    end
    ic.we = 0;
  endtask

  task automatic rand_a(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rst = $urandom_range(63) == 0;
      ia.we = $urandom_range(1);
      ia.rd_ptr = $urandom;
      ia.rd = $urandom;
      ia.rs_ptr = $urandom_range(3) == 0 ? {ia.rd_ptr, ia.rd_ptr} : 10'($urandom);
      step();
    end
    rst = 0;
  endtask

  task automatic rand_c(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rst_c = $urandom_range(63) == 0;
      ic.we = $urandom_range(1);
      ic.rd_ptr = $urandom;
      ic.rd = $urandom;
      ic.rs_ptr = $urandom_range(3) == 0 ? {ic.rd_ptr, ic.rd_ptr, ic.rd_ptr} : 15'($urandom);
      step();
    end
    rst_c = 0;
  endtask

  initial begin
    int n;
    ia.we = 0; ia.rd_ptr = 0; ia.rd = 0; ia.rs_ptr = 0;
    rst = 1;
    step(); step();
    #1;
    chk("reset_ready", ia.ready, 0);
    chk("reset_rs", ia.rs[31:0], 0);
    rst = 0;
    sweep_a(1, n);
    chk("sweep_len", n, 31);
    ia.rs_ptr = {5'd3, 5'd3};
    #1 chk("clear_write_x3", ia.rs[31:0], 0);
    rand_a(200);
    rst = 1;
    step();
    rst = 0;
    sweep_a(0, n);
    chk("sweep_len2", n, 31);
    for (int i = 0; i < 32; i++) begin
      ia.rs_ptr = {5'(31 - i), 5'(i)};
      #1;
      chk("swept_p0", ia.rs[31:0], 0);
      chk("swept_p1", ia.rs[63:32], 0);
    end
    ia.we = 1; ia.rd_ptr = 5; ia.rd = 32'hDEADBEEF;
    step();
    ia.rd_ptr = 31; ia.rd = 32'h12345678;
    step();
    ia.we = 0;
    ia.rs_ptr = {5'd31, 5'd5};
    #1;
    chk("x5_p0", ia.rs[31:0], 32'hDEADBEEF);
    chk("x31_p1", ia.rs[63:32], 32'h12345678);
    chk("x31_p1_b", ib.rs[63:32], 32'h12345678);
    ia.we = 1; ia.rd_ptr = 0; ia.rd = 32'hFFFFFFFF; ia.rs_ptr = 0;
    step();
    ia.we = 0;
    #1;
    chk("x0_p0", ia.rs[31:0], 0);
    chk("x0_p1", ia.rs[63:32], 0);
    ia.we = 1; ia.rd_ptr = 7; ia.rd = 32'h1;
    step();
    ia.rd = 32'hA5A5A5A5; ia.rs_ptr = {5'd7, 5'd7};
    #1;
    chk("bypass_p0", ia.rs[31:0], 32'hA5A5A5A5);
    chk("bypass_p1", ia.rs[63:32], 32'hA5A5A5A5);
    chk("nobypass_p0", ib.rs[31:0], 32'h1);
    chk("nobypass_p1", ib.rs[63:32], 32'h1);
    step();
    ia.we = 0;
    #1;
    chk("nobypass_after_p0", ib.rs[31:0], 32'hA5A5A5A5);
    chk("nobypass_after_p1", ib.rs[63:32], 32'hA5A5A5A5);
    rst = 1;
    step();
    rst = 0;
    repeat (10) step();
    chk("mid_sweep_ready", ia.ready, 0);
    rst = 1;
    step();
    rst = 0;
    sweep_a(0, n);
    chk("restart_sweep_len", n, 31);
    rand_a(400);
    for (int i = 0; i < 3000 && !c_done; i++) step();
    chk("c_done", c_done, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int n;
    ic.we = 0; ic.rd_ptr = 0; ic.rd = 0; ic.rs_ptr = 0;
    rst_c = 1;
    step(); step();
    rst_c = 0;
    sweep_c(n);
    chk("c_sweep_len", n, 23);
    ic.we = 1; ic.rd_ptr = 1; ic.rd = 16'h0011;
    step();
    ic.rd_ptr = 23; ic.rd = 16'h2300;
    step();
    ic.rd_ptr = 25; ic.rd = 16'hBEEF;
    step();
    ic.we = 0;
    ic.rs_ptr = {5'd0, 5'd23, 5'd1};
    #1;
    chk("c_x1", ic.rs[15:0], 16'h0011);
    chk("c_x23", ic.rs[31:16], 16'h2300);
    chk("c_x0", ic.rs[47:32], 0);
    ic.rs_ptr = {5'd25, 5'd25, 5'd25};
    #1 chk("c_ptr25", ic.rs[15:0], 0);
    rand_c(400);
    c_done = 1;
  end
endmodule
